sram_like_arbiter: RTL and testbench

SRAM_LIKE_ARBITER -- requirements
Module: sram_like_arbiter

---
 rtl/sram_arb_pkg.sv | 22 ++
 rtl/sram_like_arbiter.sv | 140 ++++++++++++++
 tb/tb_sram_like_arbiter.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types for the sram-like arbiter: FSM states, port ownership and transfer sizes.
// Imported by the arbiter RTL and by its testbench.
package sram_arb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    I_ADDR = 3'd1,
    I_WAIT = 3'd2,
    D_ADDR = 3'd3,
    D_WAIT = 3'd4
  } state_t;

  typedef enum logic {
    INST = 1'b0,
    DATA = 1'b1
  } owner_t;

  localparam logic [1:0] BYTE = 2'd0;
  localparam logic [1:0] HALF = 2'd1;
  localparam logic [1:0] WORD = 2'd2;

endpackage

// File: rtl/sram_like_arbiter.sv
// Two-port (fetch/data) arbiter onto one sram-like slave, one transaction outstanding at a time.
// Request to m_req is 1 cycle; each transaction is followed by one IDLE cycle (3 cycles/txn with a 1-cycle slave).
module sram_like_arbiter
  import sram_arb_pkg::*;
#(
  parameter int PRIORITY_MODE = 0
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,

  output logic [31:0] rdata,

  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata
);

  state_t state, state_nxt;
  owner_t last_grant, last_grant_nxt;
  logic   data_first;

  // On a tie, round-robin hands the slave to whichever port was not served last.
  assign data_first = (PRIORITY_MODE == 0) || (last_grant == INST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= INST;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    case (state)
      IDLE: begin
        if (data_req && (!inst_req || data_first)) begin
          state_nxt = D_ADDR;
        end else if (inst_req) begin
          state_nxt = I_ADDR;
        end
      end
      I_ADDR: begin
        if (!inst_req) begin
          state_nxt = IDLE;
        end else if (m_addr_ok) begin
          last_grant_nxt = INST;
          state_nxt      = m_data_ok ? IDLE : I_WAIT;
        end
      end
      I_WAIT: begin
        if (m_data_ok) state_nxt = IDLE;
      end
      D_ADDR: begin
        if (!data_req) begin
          state_nxt = IDLE;
        end else if (m_addr_ok) begin
          last_grant_nxt = DATA;
          state_nxt      = m_data_ok ? IDLE : D_WAIT;
        end
      end
      D_WAIT: begin
        if (m_data_ok) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are held low while rst is high so a response landing during reset never pulses.
  always_comb begin
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    rdata        = '0;
    m_req        = 1'b0;
    m_wr         = 1'b0;
    m_size       = '0;
    m_addr       = '0;
    m_wdata      = '0;
    if (!rst) begin
      case (state)
        I_ADDR: begin
          m_req  = inst_req;
          m_size = WORD;
          m_addr = inst_addr;
          if (inst_req && m_addr_ok) begin
            inst_addr_ok = 1'b1;
            inst_data_ok = m_data_ok;
            if (m_data_ok) rdata = m_rdata;
          end
        end
        I_WAIT: begin
          inst_data_ok = m_data_ok;
          if (m_data_ok) rdata = m_rdata;
        end
        D_ADDR: begin
          m_req   = data_req;
          m_wr    = data_wr;
          m_size  = data_size;
          m_addr  = data_addr;
          m_wdata = data_wdata;
          if (data_req && m_addr_ok) begin
            data_addr_ok = 1'b1;
            data_data_ok = m_data_ok;
            if (m_data_ok) rdata = m_rdata;
          end
        end
        D_WAIT: begin
          data_data_ok = m_data_ok;
          if (m_data_ok) rdata = m_rdata;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter: both priority modes instantiated on shared inputs, directed
// scenarios plus a randomized run checked against a transaction-level model of the port rules.
module tb_sram_like_arbiter;
  import sram_arb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        inst_req, data_req, data_wr, m_addr_ok, m_data_ok;
  logic [1:0]  data_size;
  logic [31:0] inst_addr, data_addr, data_wdata, m_rdata;

  logic        s_inst_addr_ok [2];
  logic        s_inst_data_ok [2];
  logic        s_data_addr_ok [2];
  logic        s_data_data_ok [2];
  logic [31:0] s_rdata        [2];
  logic        s_m_req        [2];
  logic        s_m_wr         [2];
  logic [1:0]  s_m_size       [2];
  logic [31:0] s_m_addr       [2];
  logic [31:0] s_m_wdata      [2];

  int checks = 0;
  int errors = 0;
  int sel    = 0;

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_dut
      sram_like_arbiter #(.PRIORITY_MODE(g)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (s_inst_addr_ok[g]),
        .inst_data_ok (s_inst_data_ok[g]),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (s_data_addr_ok[g]),
        .data_data_ok (s_data_data_ok[g]),
        .rdata        (s_rdata[g]),
        .m_req        (s_m_req[g]),
        .m_wr         (s_m_wr[g]),
        .m_size       (s_m_size[g]),
        .m_addr       (s_m_addr[g]),
        .m_wdata      (s_m_wdata[g]),
        .m_addr_ok    (m_addr_ok),
        .m_data_ok    (m_data_ok),
        .m_rdata      (m_rdata)
      );
    end
  endgenerate

  // {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}
  function automatic logic [3:0] pulses(int s);
    return {s_inst_addr_ok[s], s_inst_data_ok[s], s_data_addr_ok[s], s_data_data_ok[s]};
  endfunction

  // {m_req, m_wr, m_size, m_addr, m_wdata}
  function automatic logic [67:0] mfields(int s);
    return {s_m_req[s], s_m_wr[s], s_m_size[s], s_m_addr[s], s_m_wdata[s]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_wr = 1'b0; data_size = '0; data_addr = '0; data_wdata = '0;
    m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    data_req = 1'b1; data_addr = 32'h0000_0A00;
    inst_req = 1'b1; inst_addr = 32'h0000_0B00;
    step();
    step();
    rst = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (mfields(s) !== 68'h0) begin
        errors++; $display("FAIL reset_mfields[%0d]: got %h want 0", s, mfields(s));
      end
      checks++;
      if (pulses(s) !== 4'b0 || s_rdata[s] !== 32'h0) begin
        errors++; $display("FAIL reset_outputs[%0d]: pulses %b rdata %h want 0/0", s, pulses(s), s_rdata[s]);
      end
    end
    step();
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (mfields(s) !== {1'b1, 1'b0, BYTE, 32'h0000_0A00, 32'h0}) begin
        errors++; $display("FAIL reset_first_grant[%0d]: got %h want data request", s, mfields(s));
      end
    end
  endtask

  task automatic test_load();
    sel = 0;
    do_reset();
    data_req = 1'b1; data_wr = 1'b0; data_size = WORD; data_addr = 32'h8000_0010; data_wdata = 32'h55;
    step();
    #1;
    checks++;
    if (mfields(0) !== {1'b1, 1'b0, WORD, 32'h8000_0010, 32'h55} || pulses(0) !== 4'b0) begin
      errors++; $display("FAIL load_cycle1: fields %h pulses %b", mfields(0), pulses(0));
    end
    step();
    m_addr_ok = 1'b1;
    #1;
    checks++;
    if (pulses(0) !== 4'b0010) begin
      errors++; $display("FAIL load_addr_ok: got %b want 0010", pulses(0));
    end
    step();
    data_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (pulses(0) !== 4'b0001 || s_rdata[0] !== 32'hDEAD_BEEF || s_m_req[0] !== 1'b0) begin
      errors++; $display("FAIL load_data_ok: pulses %b rdata %h m_req %b want 0001/deadbeef/0",
                         pulses(0), s_rdata[0], s_m_req[0]);
    end
    step();
    m_data_ok = 1'b0;
    #1;
    checks++;
    if (mfields(0) !== 68'h0 || s_rdata[0] !== 32'h0) begin
      errors++; $display("FAIL load_idle_after: fields %h rdata %h want 0", mfields(0), s_rdata[0]);
    end
  endtask

  task automatic test_store_same_cycle();
    sel = 0;
    do_reset();
    data_req = 1'b1; data_wr = 1'b1; data_size = WORD; data_addr = 32'h0000_1000; data_wdata = 32'h1234_5678;
    step();
    m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = 32'hA5A5_0001;
    #1;
    checks++;
    if (mfields(0) !== {1'b1, 1'b1, WORD, 32'h0000_1000, 32'h1234_5678}) begin
      errors++; $display("FAIL store_fields: got %h", mfields(0));
    end
    checks++;
    if (pulses(0) !== 4'b0011) begin
      errors++; $display("FAIL store_both_pulses: got %b want 0011", pulses(0));
    end
    step();
    data_req = 1'b0; m_addr_ok = 1'b0;
    #1;
    checks++;
    if (pulses(0) !== 4'b0 || s_m_req[0] !== 1'b0) begin
      errors++; $display("FAIL store_back_to_idle: pulses %b m_req %b want 0000/0", pulses(0), s_m_req[0]);
    end
    m_data_ok = 1'b0;
  endtask

  task automatic test_tie_fixed();
    sel = 0;
    do_reset();
    inst_req = 1'b1; inst_addr = 32'h0000_4000;
    data_req = 1'b1; data_wr = 1'b0; data_size = HALF; data_addr = 32'h0000_2002; data_wdata = 32'hCAFE_F00D;
    step();
    m_addr_ok = 1'b1;
    #1;
    checks++;
    if (mfields(0) !== {1'b1, 1'b0, HALF, 32'h0000_2002, 32'hCAFE_F00D} || pulses(0) !== 4'b0010) begin
      errors++; $display("FAIL tie_fixed_data_first: fields %h pulses %b", mfields(0), pulses(0));
    end
    step();
    data_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = 32'h0000_BEEF;
    #1;
    checks++;
    if (pulses(0) !== 4'b0001 || s_rdata[0] !== 32'h0000_BEEF) begin
      errors++; $display("FAIL tie_fixed_data_done: pulses %b rdata %h", pulses(0), s_rdata[0]);
    end
    step();
    m_data_ok = 1'b0;
    #1;
    checks++;
    if (s_m_req[0] !== 1'b0) begin
      errors++; $display("FAIL tie_fixed_idle_gap: m_req %b want 0", s_m_req[0]);
    end
    step();
    data_wr = 1'b1;
    m_addr_ok = 1'b1;
    #1;
    checks++;
    if (mfields(0) !== {1'b1, 1'b0, WORD, 32'h0000_4000, 32'h0} || pulses(0) !== 4'b1000) begin
      errors++; $display("FAIL tie_fixed_fetch: fields %h pulses %b", mfields(0), pulses(0));
    end
    step();
    inst_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = 32'h2400_0001;
    #1;
    checks++;
    if (pulses(0) !== 4'b0100 || s_rdata[0] !== 32'h2400_0001) begin
      errors++; $display("FAIL tie_fixed_fetch_done: pulses %b rdata %h", pulses(0), s_rdata[0]);
    end
    step();
    m_data_ok = 1'b0;
  endtask

  task automatic test_round_robin();
    owner_t got [4];
    int     n    = 0;
    logic   pend = 1'b0;
    sel = 1;
    do_reset();
    inst_req = 1'b1; inst_addr = 32'h0000_0100;
    data_req = 1'b1; data_addr = 32'h0000_0200;
    for (int c = 0; c < 40 && n < 4; c++) begin
      #1;
      m_addr_ok = s_m_req[1];
      m_data_ok = pend;
      #1;
      if (s_data_addr_ok[1]) begin got[n] = DATA; n++; end
      else if (s_inst_addr_ok[1]) begin got[n] = INST; n++; end
      pend = s_data_addr_ok[1] | s_inst_addr_ok[1];
      step();
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k >= n) begin
        errors++; $display("FAIL rr_grant[%0d]: no grant within cycle budget", k);
      end else if (got[k] !== ((k % 2 == 0) ? DATA : INST)) begin
        errors++; $display("FAIL rr_grant[%0d]: got %s want %s", k, got[k].name(),
                           (k % 2 == 0) ? "DATA" : "INST");
      end
    end
    clear_inputs();
  endtask

  task automatic test_reset_inflight();
    sel = 0;
    do_reset();
    inst_req = 1'b1; inst_addr = 32'h0000_0040;
    step();
    m_addr_ok = 1'b1;
    #1;
    checks++;
    if (pulses(0) !== 4'b1000) begin
      errors++; $display("FAIL inflight_addr_ok: got %b want 1000", pulses(0));
    end
    step();
    inst_req = 1'b0; m_addr_ok = 1'b0;
    rst = 1'b1; m_data_ok = 1'b1; m_rdata = 32'h1111_2222;
    #1;
    checks++;
    if (pulses(0) !== 4'b0) begin
      errors++; $display("FAIL inflight_during_rst: pulses %b want 0000", pulses(0));
    end
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (pulses(0) !== 4'b0 || s_m_req[0] !== 1'b0 || s_rdata[0] !== 32'h0) begin
      errors++; $display("FAIL inflight_after_rst: pulses %b m_req %b rdata %h want 0", pulses(0), s_m_req[0], s_rdata[0]);
    end
    m_data_ok = 1'b0;
  endtask

  task automatic test_stray_and_abandon();
    sel = 0;
    do_reset();
    m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = 32'h7777_7777;
    #1;
    checks++;
    if (pulses(0) !== 4'b0 || pulses(1) !== 4'b0) begin
      errors++; $display("FAIL stray_pulses: got %b/%b want 0000", pulses(0), pulses(1));
    end
    step();
    m_addr_ok = 1'b0; m_data_ok = 1'b0;
    data_req = 1'b1; data_addr = 32'h0000_0300;
    step();
    #1;
    checks++;
    if (s_m_req[0] !== 1'b1 || s_m_addr[0] !== 32'h0000_0300) begin
      errors++; $display("FAIL stray_then_grant: m_req %b m_addr %h want 1/00000300", s_m_req[0], s_m_addr[0]);
    end
    step();
    data_req = 1'b0; m_addr_ok = 1'b1;
    #1;
    checks++;
    if (s_m_req[0] !== 1'b0 || pulses(0) !== 4'b0) begin
      errors++; $display("FAIL abandon_drop: m_req %b pulses %b want 0/0000", s_m_req[0], pulses(0));
    end
    step();
    m_addr_ok = 1'b0; m_data_ok = 1'b1;
    inst_req = 1'b1; inst_addr = 32'h0000_0500;
    #1;
    checks++;
    if (pulses(0) !== 4'b0 || s_m_req[0] !== 1'b0) begin
      errors++; $display("FAIL abandon_idle: pulses %b m_req %b want 0000/0", pulses(0), s_m_req[0]);
    end
    step();
    m_data_ok = 1'b0;
    #1;
    checks++;
    if (mfields(0) !== {1'b1, 1'b0, WORD, 32'h0000_0500, 32'h0}) begin
      errors++; $display("FAIL abandon_next_grant: got %h want fetch 00000500", mfields(0));
    end
    clear_inputs();
  endtask

  // Transaction-level model: a port that holds req wins when the slave path is free, per the
  // tie rule; accepted transactions complete on the slave response and cost one idle cycle.
  task automatic test_random(input int s);
    logic        free = 1'b1, acc = 1'b0, drop_i = 1'b0, drop_d = 1'b0, a, d;
    owner_t      own = INST, last = INST;
    logic [67:0] exp_f;
    logic [3:0]  exp_p;
    int          done = 0;
    sel = s;
    do_reset();
    for (int c = 0; c < 500; c++) begin
      if (drop_i) begin inst_req = 1'b0; drop_i = 1'b0; end
      if (drop_d) begin data_req = 1'b0; drop_d = 1'b0; end
      if (!inst_req && $urandom_range(0, 3) == 0) begin
        inst_req = 1'b1; inst_addr = $urandom() & 32'hFFFF_FFFC;
      end
      if (!data_req && $urandom_range(0, 3) == 0) begin
        data_req = 1'b1; data_wr = 1'($urandom_range(0, 1)); data_size = 2'($urandom_range(0, 2));
        data_addr = $urandom(); data_wdata = $urandom();
      end
      #1;
      if (free) begin
        a = ($urandom_range(0, 7) == 0); d = ($urandom_range(0, 7) == 0);
      end else if (!acc) begin
        a = 1'($urandom_range(0, 1)); d = a && ($urandom_range(0, 3) == 0);
      end else begin
        a = ($urandom_range(0, 7) == 0); d = ($urandom_range(0, 2) == 0);
      end
      m_addr_ok = a; m_data_ok = d; m_rdata = $urandom();
      #1;
      exp_f = '0;
      exp_p = '0;
      if (!free && !acc) begin
        exp_f = (own == DATA) ? {1'b1, data_wr, data_size, data_addr, data_wdata}
                              : {1'b1, 1'b0, WORD, inst_addr, 32'h0};
        if (a) exp_p = (own == DATA) ? {2'b00, 1'b1, d} : {1'b1, d, 2'b00};
      end else if (!free && d) begin
        exp_p = (own == DATA) ? 4'b0001 : 4'b0100;
      end
      checks++;
      if (!free && acc) begin
        if (s_m_req[s] !== 1'b0) begin
          errors++; $display("FAIL rnd%0d_wait_m_req c%0d: got %b want 0", s, c, s_m_req[s]);
        end
      end else if (mfields(s) !== exp_f) begin
        errors++; $display("FAIL rnd%0d_fields c%0d: got %h want %h", s, c, mfields(s), exp_f);
      end
      checks++;
      if (pulses(s) !== exp_p) begin
        errors++; $display("FAIL rnd%0d_pulses c%0d: got %b want %b", s, c, pulses(s), exp_p);
      end
      if (exp_p[2] || exp_p[0] || free) begin
        checks++;
        if (s_rdata[s] !== (free ? 32'h0 : m_rdata)) begin
          errors++; $display("FAIL rnd%0d_rdata c%0d: got %h want %h", s, c, s_rdata[s], free ? 32'h0 : m_rdata);
        end
      end
      if (free) begin
        if (data_req || inst_req) begin
          own  = (data_req && (!inst_req || s == 0 || last == INST)) ? DATA : INST;
          free = 1'b0;
          acc  = 1'b0;
        end
      end else if (!acc) begin
        if (a) begin
          last = own;
          if (own == DATA) drop_d = 1'b1; else drop_i = 1'b1;
          if (d) begin free = 1'b1; done++; end
          else acc = 1'b1;
        end
      end else if (d) begin
        free = 1'b1;
        done++;
      end
      step();
    end
    checks++;
    if (done < 20) begin
      errors++; $display("FAIL rnd%0d_progress: %0d transactions completed, want at least 20", s, done);
    end
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_load();
    test_store_same_cycle();
    test_tie_fixed();
    test_round_robin();
    test_reset_inflight();
    test_stray_and_abandon();
    test_random(0);
    test_random(1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
